// File: rtl/ssd_scan_pwm.sv
// ssd_scan_pwm: time-multiplexed scanner for NUM_DIGITS common-anode
// seven-segment digits.
//
// Features:
//   - per-digit enable (blanking) and per-digit blink
//   - global PWM brightness applied inside each digit slot
//   - one-cycle frame-complete tick
//
// Pipeline:
//   stage 0  scan counters (slot_cnt, digit_idx, frame_cnt, blink_phase)
//   stage 1  slot-start latch of the digit's data/brightness/visibility,
//            plus a delayed copy of slot_cnt aligned with that latch
//   stage 2  registered pin drive (an, seg_out)
//
// All pin outputs are registered, so the anodes never glitch. At most one
// anode is low at any time, because the anode pattern is built from a
// single latched index.
module ssd_scan_pwm #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  // Counter widths; the max(1, ...) guards keep degenerate
  // parameter values legal.
  localparam int SW    = $clog2(REFRESH_DIV);
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLICE = REFRESH_DIV >> BRIGHT_W;

  // Terminal counts, sized to their counters so every compare is
  // width-clean.
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [SW:0]   SLICE_W    = (SW+1)'(SLICE);

  // ---------------------------------------------------------------------
  // Stage 0: scan counters
  // ---------------------------------------------------------------------
  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] digit_idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  // ---------------------------------------------------------------------
  // Stage 1: slot-start latch
  // ---------------------------------------------------------------------
  logic [7:0]          cur_seg;
  logic [BRIGHT_W-1:0] cur_bright;
  logic                lit_ok;
  logic [IW-1:0]       cur_idx;
  logic [SW-1:0]       slot_q;

  // ---------------------------------------------------------------------
  // Combinational next-state / decode
  // ---------------------------------------------------------------------
  logic          slot_last;
  logic          digit_last;
  logic          frame_last;
  logic          frame_wrap;
  logic [SW-1:0] slot_nxt;
  logic [IW-1:0] digit_nxt;
  logic [FW-1:0] frame_nxt;
  logic          blink_nxt;
  logic [7:0]    sel_seg;
  logic          sel_en;
  logic          sel_blink;
  logic          sel_lit;
  logic [SW:0]   thresh;
  logic          on_nxt;

  // Counter terminal detection and wrap-explicit next values.
  always_comb begin
    slot_last  = (slot_cnt == SLOT_LAST);
    digit_last = (digit_idx == DIGIT_LAST);
    frame_last = (frame_cnt == FRAME_LAST);
    frame_wrap = slot_last & digit_last;

    slot_nxt   = slot_last ? '0 : slot_cnt + 1'b1;

    digit_nxt  = digit_idx;
    if (slot_last) begin
      digit_nxt = digit_last ? '0 : digit_idx + 1'b1;
    end

    frame_nxt  = frame_cnt;
    blink_nxt  = blink_phase;
    if (frame_wrap) begin
      frame_nxt = frame_last ? '0 : frame_cnt + 1'b1;
      if (frame_last) begin
        blink_nxt = ~blink_phase;
      end
    end
  end

  // Select the current digit's byte and control bits. A decode loop is
  // used rather than a variable part-select so that indices outside
  // 0..NUM_DIGITS-1 simply select nothing.
  always_comb begin
    sel_seg   = 8'hFF;
    sel_en    = 1'b0;
    sel_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IW'(k)) begin
        sel_seg   = seg_data[8*k +: 8];
        sel_en    = digit_en[k];
        sel_blink = blink_en[k];
      end
    end
    // Visible only if enabled, and not blanked by the blink-off phase.
    sel_lit = sel_en & ~(sel_blink & blink_phase);
  end

  // PWM compare.
  //   - slot_q is slot_cnt delayed to line up with the latched
  //     brightness.
  //   - The top brightness code still leaves the final slice (plus any
  //     remainder of REFRESH_DIV) dark, which gives the anti-ghost gap
  //     between digits.
  always_comb begin
    thresh = (SW+1)'(cur_bright) * SLICE_W;
    on_nxt = lit_ok & ({1'b0, slot_q} < thresh);
  end

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Scan counters: slot, digit, frame and blink phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      slot_cnt    <= slot_nxt;
      digit_idx   <= digit_nxt;
      frame_cnt   <= frame_nxt;
      blink_phase <= blink_nxt;
    end
  end

  // Frame tick: high for the first cycle after digit_idx wraps to 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
    end
  end

  // Slot-start latch: inputs are sampled once per slot, so input changes
  // made mid-slot only take effect from the next slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_seg    <= 8'hFF;
      cur_bright <= '0;
      lit_ok     <= 1'b0;
      cur_idx    <= '0;
    end else if (slot_cnt == '0) begin
      cur_seg    <= sel_seg;
      cur_bright <= brightness;
      lit_ok     <= sel_lit;
      cur_idx    <= digit_idx;
    end
  end

  // Delayed slot position, aligned with the latched slot data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_cnt;
    end
  end

  // Registered pin drive: when the digit is lit, exactly one anode goes
  // low and the latched segment byte is driven; otherwise everything is
  // dark.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an      <= '1;
      seg_out <= 8'hFF;
    end else if (on_nxt) begin
      an      <= ~(NUM_DIGITS'(1) << cur_idx);
      seg_out <= cur_seg;
    end else begin
      an      <= '1;
      seg_out <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_ssd_scan_pwm.sv
// tb_ssd_scan_pwm: directed and table-driven bench for ssd_scan_pwm.
// Small parameters (4 digits, 16-cycle slots, 4 brightness codes, blink
// every 2 frames) keep every expected count hand-computable.
module tb_ssd_scan_pwm;

  localparam int N  = 4;
  localparam int RD = 16;
  localparam int BW = 2;
  localparam int BF = 2;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   seg_data = '0;
  logic [3:0]    digit_en = '0;
  logic [3:0]    blink_en = '0;
  logic [1:0]    brightness = '0;
  logic [7:0]    seg_out;
  logic [3:0]    an;
  logic          frame_tick;

  always #5 clk = ~clk;

  ssd_scan_pwm #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BRIGHT_W    (BW),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_data   (seg_data),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .brightness (brightness),
    .seg_out    (seg_out),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Per-window observation counters.
  int lit_cnt [4];
  int seg_err;
  int tick_cnt;
  int tick_pos;
  int inv_err;

  typedef struct {
    logic [31:0]     seg;
    logic [3:0]      en;
    logic [3:0]      blink;
    logic [1:0]      br;
    logic [3:0][7:0] exp_lit;   // lit cycles per digit in frame 0, [d] = digit d
  } vec_t;

  vec_t vecs [6];

  // ---------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Hold reset low for 3 clock edges, checking the outputs are dark;
  // release on a negedge.
  task automatic do_reset();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_an", {28'd0, an}, 32'hF);
      check("reset_seg", {24'd0, seg_out}, 32'hFF);
    end
    reset = 1'b1;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    seg_err  = 0;
    tick_cnt = 0;
    tick_pos = -1;
    inv_err  = 0;
  endtask

  // Observe n cycles at the negedge.
  //   - Counts lit cycles per digit and frame ticks.
  //   - Checks invariants: at most one anode low, and dark segments
  //     whenever all anodes are high.
  //   - chk_seg: compare the driven byte against seg_data.
  //   - rnd:     scramble the inputs at random cycles.
  task automatic run_window(input int n, input bit chk_seg, input bit rnd);
    logic [3:0] onehot;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        tick_cnt++;
        tick_pos = i;
      end
      if ($countones(~an) > 1) inv_err++;
      if (an == 4'hF) begin
        if (seg_out !== 8'hFF) inv_err++;
      end else begin
        for (int d = 0; d < 4; d++) begin
          onehot = 4'b0001 << d;
          if (an == ~onehot) begin
            lit_cnt[d]++;
            if (chk_seg && seg_out !== seg_data[8*d +: 8]) seg_err++;
          end
        end
      end
      if (rnd && $urandom_range(0, 7) == 0) begin
        seg_data   = $urandom();
        digit_en   = 4'($urandom_range(0, 15));
        blink_en   = 4'($urandom_range(0, 15));
        brightness = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic set_inputs(input logic [31:0] s, input logic [3:0] e,
                            input logic [3:0] b, input logic [1:0] br);
    seg_data   = s;
    digit_en   = e;
    blink_en   = b;
    brightness = br;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int blink_exp [6];

    vecs[0] = '{32'h8EC0F9A4, 4'hF, 4'h0, 2'd3, {8'd12, 8'd12, 8'd12, 8'd12}};
    vecs[1] = '{32'h8EC0F9A4, 4'hF, 4'h0, 2'd1, {8'd4,  8'd4,  8'd4,  8'd4}};
    vecs[2] = '{32'h12345678, 4'hF, 4'h0, 2'd0, {8'd0,  8'd0,  8'd0,  8'd0}};
    vecs[3] = '{32'h8EC0F9A4, 4'hB, 4'h1, 2'd3, {8'd12, 8'd0,  8'd12, 8'd12}};
    vecs[4] = '{32'h00000000, 4'h0, 4'h0, 2'd3, {8'd0,  8'd0,  8'd0,  8'd0}};
    vecs[5] = '{32'h00FF55AA, 4'h6, 4'hF, 2'd2, {8'd0,  8'd8,  8'd8,  8'd0}};

    // Reset and release: exact anode sequence from an expected queue.
    set_inputs(32'h0000_0000, 4'hF, 4'h0, 2'd3);
    do_reset();
    exp_q.push_back(32'hF);
    for (int k = 2;  k <= 13; k++) exp_q.push_back(32'hE);
    for (int k = 14; k <= 17; k++) exp_q.push_back(32'hF);
    for (int k = 18; k <= 29; k++) exp_q.push_back(32'hD);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("release_an", {28'd0, an}, exp_q.pop_front());
    end

    // Table-driven: one frame per configuration, starting from reset.
    for (int v = 0; v < 6; v++) begin
      set_inputs(vecs[v].seg, vecs[v].en, vecs[v].blink, vecs[v].br);
      do_reset();
      @(negedge clk);
      check($sformatf("v%0d_first_dark", v), {28'd0, an}, 32'hF);
      clear_counts();
      run_window(64, 1'b1, 1'b0);
      for (int d = 0; d < 4; d++)
        check($sformatf("v%0d_lit_d%0d", v, d), lit_cnt[d],
              32'(vecs[v].exp_lit[d]));
      check($sformatf("v%0d_seg", v), seg_err, 0);
      check($sformatf("v%0d_tick_cnt", v), tick_cnt, 1);
      check($sformatf("v%0d_tick_pos", v), tick_pos, 62);
      check($sformatf("v%0d_invariant", v), inv_err, 0);
    end

    // Brightness 3 -> 1 while slot_cnt == 2: the current slot keeps 12
    // lit cycles, the next slot gets 4.
    set_inputs(32'h8EC0F9A4, 4'hF, 4'h0, 2'd3);
    do_reset();
    clear_counts();
    run_window(2, 1'b1, 1'b0);
    brightness = 2'd1;
    run_window(31, 1'b1, 1'b0);
    check("brt_change_d0", lit_cnt[0], 12);
    check("brt_change_d1", lit_cnt[1], 4);

    // Blink across 6 frames: digit 0 visible, dark, visible; digit 2
    // never lit.
    blink_exp = '{12, 12, 0, 0, 12, 12};
    set_inputs(32'h8EC0F9A4, 4'hB, 4'h1, 2'd3);
    do_reset();
    run_window(1, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      clear_counts();
      run_window(64, 1'b1, 1'b0);
      check($sformatf("blink_f%0d_d0", f), lit_cnt[0], blink_exp[f]);
      check($sformatf("blink_f%0d_d1", f), lit_cnt[1], 12);
      check($sformatf("blink_f%0d_d2", f), lit_cnt[2], 0);
    end

    // Mid-scan reset in the blink-off phase (frame 2, digit 2,
    // slot_cnt 7): outputs go dark at once, and digit 0 is visible again
    // after restart.
    set_inputs(32'h8EC0F9A4, 4'hF, 4'h1, 2'd3);
    do_reset();
    repeat (167) @(negedge clk);
    check("pre_midrst_an", {28'd0, an}, 32'hB);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_an", {28'd0, an}, 32'hF);
    check("midrst_seg", {24'd0, seg_out}, 32'hFF);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_first_dark", {28'd0, an}, 32'hF);
    clear_counts();
    run_window(16, 1'b1, 1'b0);
    check("midrst_d0_lit", lit_cnt[0], 12);
    check("midrst_seg", seg_err, 0);

    // Random inputs over 20 frames: invariants and frame tick count.
    set_inputs($urandom(), 4'hF, 4'h0, 2'd3);
    do_reset();
    clear_counts();
    run_window(1281, 1'b0, 1'b1);
    check("rand_invariant", inv_err, 0);
    check("rand_ticks", tick_cnt, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_pwm.md
Name: ssd_scan_pwm

Overview:
- Parametrised successor to the board's fixed 8-digit seven-segment scanner.
- Time-multiplexes NUM_DIGITS common-anode digits from a packed segment bus.
- Adds per-digit enable (blanking), per-digit blink, global PWM brightness and a frame-complete tick.
- Sits between display-formatting logic (elevator floor/status encoders) and the board pins.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (>=1).
- REFRESH_DIV, 100000, clk cycles per digit slot (must be >= 2**BRIGHT_W).
- BRIGHT_W, 4, brightness code width; slice = REFRESH_DIV >> BRIGHT_W.
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- seg_data  in  8*NUM_DIGITS  digit k at [8k+7:8k] = {p,g,f,e,d,c,b,a}, active-low, digit 0 rightmost.
- digit_en  in  NUM_DIGITS  1 = digit may light; 0 = digit forced dark.
- blink_en  in  NUM_DIGITS  1 = digit dark during blink-off phase.
- brightness  in  BRIGHT_W  duty code; 0 = dark, max = (2**BRIGHT_W-1)/2**BRIGHT_W duty.
- seg_out  out  8  {p,g,f,e,d,c,b,a} to pins, active-low.
- an  out  NUM_DIGITS  anode selects, active-low, one-hot-low or all ones.
- frame_tick  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (reset==0 at posedge):
  - slot_cnt=0, digit_idx=0, frame_cnt=0, blink_phase=0.
  - an=all ones, seg_out=8'hFF, frame_tick=0.
  - Applies mid-scan with identical result.
- Widths:
  - slot_cnt: $clog2(REFRESH_DIV) bits.
  - digit_idx: max(1,$clog2(NUM_DIGITS)) bits.
  - frame_cnt: max(1,$clog2(BLINK_FRAMES)) bits.
  - All counters wrap explicitly, never by overflow.
- Slot counter:
  - slot_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it returns to 0 and digit_idx advances.
  - digit_idx wraps NUM_DIGITS-1 -> 0; unused codes are never reached.
- Slot-start latch (slot_cnt==0): captures cur_seg = seg_data[digit_idx], cur_bright = brightness, and lit_ok = digit_en[digit_idx] & ~(blink_en[digit_idx] & blink_phase).
  - Input changes mid-slot take effect at the next slot.
- Drive: on = lit_ok & (slot_cnt < cur_bright*slice), evaluated each cycle and registered.
  - on=1: an = ~(1<<digit_idx), seg_out = cur_seg.
  - on=0: an = all ones, seg_out = 8'hFF.
  - Latency: first lit output appears 2 cycles after the slot's slot_cnt==0 edge (latch, then register).
- Frame/blink:
  - frame_tick=1 for exactly the cycle after digit_idx wraps to 0.
  - frame_cnt counts frames; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - blink_phase=0 is the visible phase; the first phase after reset lasts BLINK_FRAMES frames.
- Boundary cases:
  - brightness=0: never lit.
  - brightness max: dark for the last slice + REFRESH_DIV mod 2**BRIGHT_W cycles of each slot. This is the anti-ghost gap.
  - NUM_DIGITS=1: digit_idx stays 0; frame_tick pulses every slot.
  - digit_en and blink_en both 0: dark.
  - blink_en=1 with blink_phase=0: lit normally.
- Invariant: never more than one an bit low.

Test Plan:
Bench params: NUM_DIGITS=4, REFRESH_DIV=16, BRIGHT_W=2 (slice=4), BLINK_FRAMES=2.

1. Reset and release: hold reset=0 for 3 cycles, seg_data=32'h0000_0000, digit_en=4'hF, blink_en=0, brightness=3 -> during reset an=4'hF, seg_out=8'hFF. After release an=4'b1110 for 12 consecutive cycles, then dark for 4 cycles, then 4'b1101 for 12.
2. Data routing: seg_data={8'h8E,8'hC0,8'hF9,8'hA4}, brightness=3 -> seg_out sequence A4, F9, C0, 8E with an 1110, 1101, 1011, 0111. frame_tick pulses once per 64 cycles, on the cycle after digit_idx returns to 0.
3. Brightness: brightness=1 -> 4 lit cycles per 16-cycle slot. brightness=0 -> an=4'hF permanently. Change brightness 3->1 at slot_cnt=2 -> current slot keeps 12 lit cycles, next slot has 4.
4. Enable/blink: digit_en=4'b1011, blink_en=4'b0001 -> digit 2 never lit. Digit 0 lit for frames 0-1, dark for frames 2-3, lit again for frames 4-5.
5. Mid-scan reset: assert reset=0 for 1 cycle while digit_idx=2, slot_cnt=7 -> next cycle an=4'hF, seg_out=8'hFF. Scanning restarts at digit 0 with blink_phase=0.
6. Invariant check across 20 frames with random inputs changed at random cycles -> $countones(~an) <= 1 every cycle; seg_out=8'hFF whenever an=all ones.
